seq_checker: RTL and testbench
==============================

# seq_checker

Stream reader that consumes a WIDTH-bit incrementing-count data stream, as produced by the counter-driven data sources in this design, and checks that each accepted word equals the previous word plus one. It acquires lock after a run of correct words, flags and counts discontinuities while locked, and drops lock after repeated consecutive errors. It sits at the receive end of a valid/ready link and exposes status and counters for test benches and debug registers.

## Interface

- WIDTH, 8, data word width in bits (≥ 1)
- LOCK_COUNT, 4, consecutive in-sequence words needed to enter lock (≥ 1)
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock (≥ 1)
- CNT_WIDTH, 16, width of error and word counters

- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- data_i  input  WIDTH  received data word
- valid_i  input  1  data_i is valid
- ready_o  output  1  checker can accept; a transfer occurs when valid_i && ready_o
- clear_i  input  1  clears error_count_o and word_count_o (state is kept)
- locked_o  output  1  sequence lock acquired
- error_o  output  1  one-cycle pulse per mismatch detected while locked
- error_count_o  output  CNT_WIDTH  mismatches while locked, saturating
- word_count_o  output  CNT_WIDTH  accepted transfers, wraps modulo 2^CNT_WIDTH
- expected_o  output  WIDTH  next expected word

## Operation

- The only clock is clk_i; rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values: ready_o 0, locked_o 0, error_o 0, error_count_o 0, word_count_o 0, expected_o 0, state SEARCH, good/bad run counters 0.
- ready_o: 0 in the reset cycle, 1 from the first cycle after rst_i is low, constant 1 thereafter. The block never back-pressures.
- Cycles without a transfer change nothing except error_o, which returns to 0.
- Every transfer sets expected_o to (data_i + 1) mod 2^WIDTH, so the checker always resynchronises to the received value. 0xFF…F followed by 0 is in sequence.
- Every transfer increments word_count_o.
- State machine:
  - SEARCH: the first transfer seeds expected_o and sets good = 1. Go to LOCKED if LOCK_COUNT = 1, else go to VERIFY.
  - VERIFY, data_i == expected_o: good++. When good reaches LOCK_COUNT, go to LOCKED, set bad = 0 and locked_o = 1.
  - VERIFY, mismatch: good = 1 (reseed), stay in VERIFY. No error is flagged.
  - LOCKED, match: bad = 0.
  - LOCKED, mismatch: error_o = 1 for one cycle, error_count_o++ (saturates at all-ones), bad++. When bad reaches LOSS_COUNT, go to SEARCH, set locked_o = 0 and good = 0.
- Mismatches outside LOCKED never assert error_o and never count.
- clear_i has priority below same-cycle events. A counter is cleared first, then the same-cycle increment is applied, so clear plus error gives error_count_o = 1 and clear plus transfer gives word_count_o = 1.
- rst_i asserted mid-stream aborts everything. The transfer in the reset cycle is ignored.

## Timing

- Latency from a transfer edge to updated locked_o, error_o, counters and expected_o is 1 cycle.
- locked_o rises in the cycle after the LOCK_COUNT-th in-sequence transfer.
- locked_o falls in the same cycle as the error_o pulse for the LOSS_COUNT-th consecutive mismatch.
- Back-to-back transfers are supported at one word per cycle. Gaps in valid_i of any length do not affect sequence checking.

## Test plan

- Reset, then stream 0..9 with no gaps (defaults) → locked_o = 1 one cycle after the word 3 transfer; error_o never pulses; final word_count_o = 10, expected_o = 10.
- WIDTH = 8, locked, stream 0xFD, 0xFE, 0xFF, 0x00, 0x01 → no error_o; expected_o = 0x02.
- Locked on 10, 11, 12, 13, then 99, 100, 101 → a single error_o pulse after the 99 transfer; error_count_o = 1; locked_o stays 1; expected_o = 102.
- Locked, then 50, 7, 200 (LOSS_COUNT = 3) → three error_o pulses; error_count_o = 3; locked_o = 0 after 200. Then 201..204 → relock after 204 with no new errors.
- Locked stream with random valid_i gaps, clear_i asserted in the same cycle as a mismatching transfer → error_count_o = 1, word_count_o = 1, with no false errors caused by the gaps.
- rst_i pulsed for one cycle while locked and streaming → the next cycle shows all outputs at reset values and ready_o = 0; ready_o = 1 one cycle later and the lock sequence restarts from SEARCH.

Source files
------------

// File: rtl/seq_checker.sv
// Receive-side checker for an incrementing-count stream:
// acquires lock, flags discontinuities, drops lock on repeated misses.
module seq_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [CNT_WIDTH-1:0] error_count_o,
  output logic [CNT_WIDTH-1:0] word_count_o,
  output logic [WIDTH-1:0]     expected_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] LOSS_N = BW'(LOSS_COUNT);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t         state;
  logic [GW-1:0]  good;
  logic [BW-1:0]  bad;

  logic                 xfer;
  logic                 match;
  logic [GW-1:0]        good_inc;
  logic [BW-1:0]        bad_inc;
  logic [CNT_WIDTH-1:0] ec_base;
  logic [CNT_WIDTH-1:0] wc_base;

  assign xfer     = valid_i && ready_o;
  assign match    = (data_i == expected_o);
  assign good_inc = good + GW'(1);
  assign bad_inc  = bad + BW'(1);
  // clear acts first so a same-cycle increment lands on zero
  assign ec_base  = clear_i ? '0 : error_count_o;
  assign wc_base  = clear_i ? '0 : word_count_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= SEARCH;
      good          <= '0;
      bad           <= '0;
      ready_o       <= 1'b0;
      locked_o      <= 1'b0;
      error_o       <= 1'b0;
      error_count_o <= '0;
      word_count_o  <= '0;
      expected_o    <= '0;
    end else begin
      ready_o <= 1'b1;
      error_o <= 1'b0;
      if (clear_i) begin
        error_count_o <= '0;
        word_count_o  <= '0;
      end
      if (xfer) begin
        expected_o   <= data_i + WIDTH'(1);
        word_count_o <= wc_base + CNT_WIDTH'(1);
        unique case (state)
          SEARCH: begin
            good <= GW'(1);
            if (LOCK_COUNT == 1) begin
              state    <= LOCKED;
              bad      <= '0;
              locked_o <= 1'b1;
            end else begin
              state <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              good <= good_inc;
              if (good_inc == LOCK_N) begin
                state    <= LOCKED;
                bad      <= '0;
                locked_o <= 1'b1;
              end
            end else begin
              good <= GW'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              bad <= '0;
            end else begin
              error_o <= 1'b1;
              bad     <= bad_inc;
              if (ec_base != '1)
                error_count_o <= ec_base + CNT_WIDTH'(1);
              if (bad_inc == LOSS_N) begin
                state    <= SEARCH;
                good     <= '0;
                locked_o <= 1'b0;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_checker.sv
// Directed and randomized bench for seq_checker,
// checked against a behavioural lock/error model.
module tb_seq_checker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        ready_o;
  logic        locked_o;
  logic        error_o;
  logic [15:0] error_count_o;
  logic [15:0] word_count_o;
  logic [7:0]  expected_o;

  int checks = 0;
  int failures = 0;

  bit   m_ready, m_locked, m_search, m_err;
  int   m_run, m_miss, m_ec, m_wc;
  logic [7:0] m_exp;

  seq_checker dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .clear_i       (clear_i),
    .locked_o      (locked_o),
    .error_o       (error_o),
    .error_count_o (error_count_o),
    .word_count_o  (word_count_o),
    .expected_o    (expected_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v,
                       input bit clr, input logic [7:0] d);
    bit hit;
    if (r) begin
      m_ready = 0; m_locked = 0; m_search = 1;
      m_err = 0; m_run = 0; m_miss = 0;
      m_ec = 0; m_wc = 0; m_exp = '0;
      return;
    end
    m_err = 0;
    if (clr) begin m_ec = 0; m_wc = 0; end
    if (v && m_ready) begin
      hit = (d == m_exp);
      m_wc = (m_wc + 1) % 65536;
      m_exp = d + 8'd1;
      if (!m_locked) begin
        if (m_search) begin
          m_run = 1; m_search = 0;
        end else begin
          m_run = hit ? m_run + 1 : 1;
        end
        if (m_run >= 4) begin
          m_locked = 1; m_miss = 0;
        end
      end else if (hit) begin
        m_miss = 0;
      end else begin
        m_err = 1;
        if (m_ec < 65535) m_ec++;
        m_miss++;
        if (m_miss == 3) begin
          m_locked = 0; m_search = 1; m_run = 0;
        end
      end
    end
    m_ready = 1;
  endtask

  task automatic step(input bit r, input bit v,
                      input bit clr, input logic [7:0] d);
    @(negedge clk_i);
    rst_i = r; valid_i = v; clear_i = clr; data_i = d;
    @(posedge clk_i);
    model(r, v, clr, d);
    #1;
    chk("ready", ready_o, m_ready);
    chk("locked", locked_o, m_locked);
    chk("error", error_o, m_err);
    chk("err_cnt", error_count_o, m_ec);
    chk("word_cnt", word_count_o, m_wc);
    chk("expected", expected_o, m_exp);
  endtask

  task automatic send(input logic [7:0] d);
    step(0, 1, 0, d);
  endtask

  task automatic do_reset();
    step(1, 1, 0, 8'h55);
    step(0, 1, 0, 8'h66);
  endtask

  initial begin
    logic [7:0] nd;
    int pulses;

    // reset state; transfer in reset cycle ignored
    do_reset();
    chk("rst_wc", word_count_o, 0);

    // 0..9 back to back
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'(i));
      chk("lock_time", locked_o, i >= 3);
      pulses += error_o;
    end
    chk("no_err_run", pulses, 0);
    chk("wc10", word_count_o, 10);
    chk("exp10", expected_o, 10);

    // wrap from all-ones to zero
    do_reset();
    for (int i = 8'hF9; i <= 9'h101; i++)
      send(8'(i));
    chk("wrap_exp", expected_o, 8'h02);
    chk("wrap_ec", error_count_o, 0);

    // single discontinuity
    do_reset();
    for (int i = 10; i < 14; i++) send(8'(i));
    send(8'd99);
    chk("jump_pulse", error_o, 1);
    send(8'd100);
    send(8'd101);
    chk("jump_ec", error_count_o, 1);
    chk("jump_lock", locked_o, 1);
    chk("jump_exp", expected_o, 102);

    // loss of lock, then relock
    do_reset();
    for (int i = 0; i < 4; i++) send(8'(i));
    send(8'd50);
    send(8'd7);
    chk("loss_mid", locked_o, 1);
    send(8'd200);
    chk("loss_ec", error_count_o, 3);
    chk("loss_lock", locked_o, 0);
    for (int i = 201; i <= 204; i++) begin
      send(8'(i));
      chk("relock", locked_o, i == 204);
    end
    chk("relock_ec", error_count_o, 3);

    // gaps, then clear with a mismatch
    do_reset();
    nd = 8'd30;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        send(nd); nd++;
      end else begin
        step(0, 0, 0, 8'($urandom));
      end
    end
    chk("gap_lock", locked_o, 1);
    chk("gap_ec", error_count_o, 0);
    step(0, 1, 1, nd + 8'd9);
    chk("clr_ec", error_count_o, 1);
    chk("clr_wc", word_count_o, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) != 0)
        nd = m_exp;
      else
        nd = 8'($urandom);
      step(0, $urandom_range(3, 0) != 0,
           $urandom_range(31, 0) == 0, nd);
    end

    // reset mid-stream while locked
    for (int i = 0; i < 6; i++) send(m_exp);
    chk("pre_rst_lock", locked_o, 1);
    step(1, 1, 0, m_exp);
    chk("rst_ready", ready_o, 0);
    chk("rst_lock", locked_o, 0);
    step(0, 1, 0, 8'd0);
    chk("rst_ready1", ready_o, 1);
    for (int i = 1; i <= 4; i++) begin
      send(8'(i));
      chk("rst_relock", locked_o, i == 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
